// File: rtl/start_token_srl_fifo_pkg.sv
// -----------------------------------------------------------------------------
// start_token_srl_fifo_pkg
//   Shared definitions for the SRL-backed start-token FIFO:
//     - clog2      : ceiling log2, used to derive the read-address width
//     - op_e       : per-cycle operation encoding {push, pop}
//     - EMPTY_N_RST, FULL_N_RST : handshake flag values while in reset
//   The occupancy type depends on the instance's ADDR_WIDTH, so each user
//   declares it locally as logic [ADDR_WIDTH:0].
// -----------------------------------------------------------------------------
package start_token_srl_fifo_pkg;

    localparam logic EMPTY_N_RST = 1'b0;
    localparam logic FULL_N_RST  = 1'b1;

    // Bit order matches {push, pop} so the strobes can be cast directly.
    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_BOTH = 2'b11
    } op_e;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        for (int i = 0; i < 32; i++) begin
            if (v > 0) begin
                result = result + 1;
                v      = v >> 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/start_token_srl_fifo_storage.sv
// -----------------------------------------------------------------------------
// start_token_srl_storage
//   DEPTH x DATA_WIDTH shift-register array. On we, every entry moves up one
//   index and din lands in index 0, so the oldest entry sits at the highest
//   occupied index. Read is asynchronous at addr.
//   Ports:
//     clk  : rising-edge clock
//     we   : shift enable (the FIFO's effective push)
//     addr : read index
//     din  : data shifted into index 0
//     dout : entry at addr
// -----------------------------------------------------------------------------
module start_token_srl_storage #(
    parameter int DATA_WIDTH = 1,
    parameter int ADDR_WIDTH = 1,
    parameter int DEPTH      = 2
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    // NOTE: the array has no reset on purpose; a reset term would stop the
    // tools from mapping it onto shift-register primitives, and stale
    // contents are never observed because occupancy gates every read.
    // NOTE: sequential state is written with non-blocking assignments so each
    // entry captures its neighbour's pre-edge value, giving a true shift.
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                r_mem[i] <= r_mem[i-1];
            end
        end
    end

    assign dout = r_mem[addr];

endmodule

// File: rtl/start_token_srl_fifo.sv
// -----------------------------------------------------------------------------
// start_token_srl_fifo
//   Control and read-side front end of an SRL-backed start-token FIFO.
//   Tracks occupancy, drives the shift-register read address and produces
//   registered full/empty handshakes. No combinational write-to-read path.
//   Ports:
//     clk, reset         : clock; asynchronous active-high reset
//     if_write_ce/if_write/if_din : producer side, push when if_full_n
//     if_full_n          : at least one free entry
//     if_read_ce/if_read : consumer side, pop when if_empty_n
//     if_dout            : oldest entry, valid while if_empty_n
//     if_empty_n         : at least one entry held
//     if_num_data_valid  : current occupancy 0..DEPTH
//     if_fifo_cap        : constant DEPTH
// -----------------------------------------------------------------------------
module start_token_srl_fifo
    import start_token_srl_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 1,
    parameter int DEPTH      = 2,
    parameter int ADDR_WIDTH = clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  if_write_ce,
    input  logic                  if_write,
    input  logic [DATA_WIDTH-1:0] if_din,
    output logic                  if_full_n,
    input  logic                  if_read_ce,
    input  logic                  if_read,
    output logic [DATA_WIDTH-1:0] if_dout,
    output logic                  if_empty_n,
    output logic [ADDR_WIDTH:0]   if_num_data_valid,
    output logic [ADDR_WIDTH:0]   if_fifo_cap
);

    typedef logic [ADDR_WIDTH:0] occ_t;

    occ_t                  r_count;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_empty_n;
    logic                  r_full_n;

    logic                  w_push;
    logic                  w_pop;
    op_e                   w_op;
    occ_t                  w_count_next;
    logic [ADDR_WIDTH-1:0] w_addr_next;
    logic                  w_empty_n_next;
    logic                  w_full_n_next;

    // Qualified by the registered flags, so a push while full or a pop while
    // empty never reaches the state below.
    assign w_push = if_write & if_write_ce & r_full_n;
    assign w_pop  = if_read  & if_read_ce  & r_empty_n;
    assign w_op   = op_e'({w_push, w_pop});

    // NOTE: every signal written here gets a default first, so no path through
    // the case can leave one unassigned and infer a latch.
    always_comb begin
        w_count_next = r_count;
        w_addr_next  = r_addr;
        case (w_op)
            OP_PUSH: w_count_next = r_count + occ_t'(1);
            OP_POP:  w_count_next = r_count - occ_t'(1);
            default: w_count_next = r_count;  // idle, or push+pop cancel out
        endcase
        // A push+pop keeps count, so addr is kept too: the shift itself moves
        // the next-oldest entry into the slot being read.
        if (w_count_next != '0) begin
            w_addr_next = ADDR_WIDTH'(w_count_next - occ_t'(1));
        end else begin
            w_addr_next = '0;
        end
        w_empty_n_next = (w_count_next != '0);
        w_full_n_next  = (w_count_next != occ_t'(DEPTH));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count   <= '0;
            r_addr    <= '0;
            r_empty_n <= EMPTY_N_RST;
            r_full_n  <= FULL_N_RST;
        end else begin
            r_count   <= w_count_next;
            r_addr    <= w_addr_next;
            r_empty_n <= w_empty_n_next;
            r_full_n  <= w_full_n_next;
        end
    end

    start_token_srl_storage #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH)
    ) u_storage (
        .clk  (clk),
        .we   (w_push),
        .addr (r_addr),
        .din  (if_din),
        .dout (if_dout)
    );

    assign if_full_n         = r_full_n;
    assign if_empty_n        = r_empty_n;
    assign if_num_data_valid = r_count;
    assign if_fifo_cap       = occ_t'(DEPTH);

endmodule

// File: tb/tb_start_token_srl_fifo.sv
// -----------------------------------------------------------------------------
// tb_start_token_srl_fifo
//   Directed and random stimulus for start_token_srl_fifo (DEPTH=4, 8-bit
//   tokens). A queue holds the expected tokens, oldest at the front; flags
//   and occupancy follow from its size.
// -----------------------------------------------------------------------------
module tb_start_token_srl_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          if_write_ce;
    logic          if_write;
    logic [DW-1:0] if_din;
    logic          if_full_n;
    logic          if_read_ce;
    logic          if_read;
    logic [DW-1:0] if_dout;
    logic          if_empty_n;
    logic [AW:0]   if_num_data_valid;
    logic [AW:0]   if_fifo_cap;

    int n_vec  = 0;
    int n_miss = 0;

    logic [DW-1:0] model_q [$];

    always #5 clk = ~clk;

    start_token_srl_fifo #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .if_write_ce       (if_write_ce),
        .if_write          (if_write),
        .if_din            (if_din),
        .if_full_n         (if_full_n),
        .if_read_ce        (if_read_ce),
        .if_read           (if_read),
        .if_dout           (if_dout),
        .if_empty_n        (if_empty_n),
        .if_num_data_valid (if_num_data_valid),
        .if_fifo_cap       (if_fifo_cap)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Compares every output against the queue model.
    task automatic check_all(input string tag);
        int sz;
        sz = model_q.size();
        check({tag, ".empty_n"}, 32'(if_empty_n), 32'(sz != 0));
        check({tag, ".full_n"},  32'(if_full_n),  32'(sz != DEPTH));
        check({tag, ".count"},   32'(if_num_data_valid), 32'(sz));
        if (sz != 0) begin
            check({tag, ".dout"}, 32'(if_dout), 32'(model_q[0]));
        end
    endtask

    // One clock: drive, let the edge pass, update the model, check at edge+1.
    task automatic step(input string tag, input logic w, input logic wce,
                        input logic [DW-1:0] d, input logic r, input logic rce);
        logic do_push;
        logic do_pop;
        if_write    = w;
        if_write_ce = wce;
        if_din      = d;
        if_read     = r;
        if_read_ce  = rce;
        do_push = w && wce && (model_q.size() < DEPTH);
        do_pop  = r && rce && (model_q.size() > 0);
        @(posedge clk);
        if (do_pop)  void'(model_q.pop_front());
        if (do_push) model_q.push_back(d);
        #1;
        check_all(tag);
    endtask

    initial begin
        reset       = 1'b1;
        if_write_ce = 1'b0;
        if_write    = 1'b0;
        if_din      = '0;
        if_read_ce  = 1'b0;
        if_read     = 1'b0;

        // Reset held 3 cycles, then idle.
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check_all("reset");
        check("fifo_cap", 32'(if_fifo_cap), 32'(DEPTH));
        for (int i = 0; i < 5; i++) step("idle", 0, 0, 8'h00, 0, 0);

        // Fill A..D, then hold write while full.
        step("fill_a", 1, 1, 8'hA1, 0, 0);
        step("fill_b", 1, 1, 8'hB2, 0, 0);
        step("fill_c", 1, 1, 8'hC3, 0, 0);
        step("fill_d", 1, 1, 8'hD4, 0, 0);
        step("full_hold0", 1, 1, 8'hEE, 0, 0);
        step("full_hold1", 1, 1, 8'hEF, 0, 0);
        // Push+pop while full: only the pop takes effect.
        step("full_both", 1, 1, 8'h55, 1, 1);
        check("full_both.cnt3", 32'(if_num_data_valid), 32'(DEPTH - 1));
        step("drain_b", 0, 0, 8'h00, 1, 1);
        step("drain_c", 0, 0, 8'h00, 1, 1);
        step("drain_d", 0, 0, 8'h00, 1, 1);

        // Push+pop at count=2 holding X, Y.
        step("push_x", 1, 1, 8'h11, 0, 0);
        step("push_y", 1, 1, 8'h22, 0, 0);
        step("both_z", 1, 1, 8'h33, 1, 1);
        step("pop_y", 0, 0, 8'h00, 1, 1);
        step("pop_z", 0, 0, 8'h00, 1, 1);

        // Empty-side collision: pop blocked, push succeeds.
        step("empty_both", 1, 1, 8'h77, 1, 1);
        step("pop_w", 0, 0, 8'h00, 1, 1);

        // Clock-enable gating on both sides.
        step("wce_off", 1, 0, 8'h99, 0, 0);
        step("push_g", 1, 1, 8'h5A, 0, 0);
        step("rce_off", 0, 0, 8'h00, 1, 0);
        step("pop_g", 0, 0, 8'h00, 1, 1);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            step("rand", 1'($urandom), 1'($urandom_range(0, 3) != 0), 8'($urandom),
                 1'($urandom), 1'($urandom_range(0, 3) != 0));
        end

        // Reach count=3, then assert reset between edges.
        while (model_q.size() > 0) step("pre_rst_drain", 0, 0, 8'h00, 1, 1);
        step("pre_rst0", 1, 1, 8'hC0, 0, 0);
        step("pre_rst1", 1, 1, 8'hC1, 0, 0);
        step("pre_rst2", 1, 1, 8'hC2, 0, 0);
        if_write = 1'b0;
        #2;
        reset = 1'b1;
        model_q.delete();
        #1;
        check_all("async_rst");
        @(negedge clk);
        reset = 1'b0;
        step("post_rst", 0, 0, 8'h00, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/start_token_srl_fifo.md
Name: start_token_srl_fifo

Overview:
- Control and read-side front end for an SRL-backed start-token FIFO between dataflow processes: tracks occupancy, drives the shift-register read address, and exposes full/empty handshakes.
- The producer asserts a start token on the write port. The consumer process sees the token on the read port and retires it with if_read.
- Storage is a shift register: every write shifts all entries by one; the oldest entry is read at index count-1.

Parameters:
- DATA_WIDTH, 1, token/payload width in bits.
- ADDR_WIDTH, 1, read-address width; must equal clog2(DEPTH).
- DEPTH, 2, entry capacity; legal range 2 to 2**ADDR_WIDTH.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- if_write_ce  in  1  write clock enable.
- if_write  in  1  producer push request.
- if_din  in  DATA_WIDTH  push data.
- if_full_n  out  1  high when at least one free entry exists.
- if_read_ce  in  1  read clock enable.
- if_read  in  1  consumer pop request.
- if_dout  out  DATA_WIDTH  oldest entry; valid while if_empty_n=1.
- if_empty_n  out  1  high when at least one entry is held.
- if_num_data_valid  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
- if_fifo_cap  out  ADDR_WIDTH+1  constant DEPTH.

Behaviour:
- Reset (asynchronous, active-high):
  - count=0, addr=0, if_empty_n=0, if_full_n=1, if_num_data_valid=0.
  - Storage contents are not reset.
  - Reset asserted mid-operation discards all tokens immediately, without waiting for a clock edge.
- Effective strobes:
  - push = if_write & if_write_ce & if_full_n.
  - pop = if_read & if_read_ce & if_empty_n.
  - A push while full and a pop while empty are ignored; no state changes.
- Storage update: on push, every entry shifts up by one index and if_din is written to index 0.
- Occupancy, updated at the clock edge:
  - push only: count+1.
  - pop only: count-1.
  - push and pop together: count unchanged.
  - neither: hold.
- Read address:
  - addr = count-1 when count>0, otherwise 0. It is held in a register and updated in the same edge as count.
  - Push and pop together leave addr unchanged; the shift moves the next-oldest entry into addr.
- if_dout = storage[addr], combinational from the registered addr. It is don't-care when empty.
- Flags are registered, computed from the next count:
  - if_empty_n_next = (count_next != 0).
  - if_full_n_next = (count_next != DEPTH).
- Latency:
  - A push is visible on if_empty_n/if_dout in the next cycle.
  - A pop frees a slot on if_full_n in the next cycle.
  - There is no combinational path from write to read.
- Boundary: empty with push and pop requested together. Pop is blocked (empty_n=0) and the push succeeds: count becomes 1, no fall-through bypass.
- Boundary: full with push and pop requested together. Push is blocked (full_n=0) and the pop succeeds: count becomes DEPTH-1, if_full_n rises next cycle.
- Wrap-around: count never leaves 0..DEPTH; the flags prevent overflow and underflow.
- if_num_data_valid mirrors count. if_fifo_cap is tied to DEPTH.

Decomposition:
- Shared package holds:
  - clog2 helper;
  - occupancy type, width ADDR_WIDTH+1;
  - constants for the flag reset values (EMPTY_N_RST=0, FULL_N_RST=1).
- One sub-module: start_token_srl_storage. It holds the DEPTH x DATA_WIDTH shift-register array, with ports clk, we, addr, din, dout.
  - we = push.
  - It has no reset, so it can infer SRL primitives.
- Control (count, addr, flags) stays in the top module.

Test Plan:
- Reset then idle: hold reset 3 cycles, release → if_empty_n=0, if_full_n=1, if_num_data_valid=0; no change after 5 idle cycles.
- Fill/drain order, DEPTH=2: push 0x1 then 0x0 (DATA_WIDTH=1), no pops → if_full_n=0 after 2nd edge. Then pop twice → if_dout reads 1 then 0, if_empty_n=0 afterwards, if_full_n=1.
- Full-blocked push, DEPTH=4: fill with A,B,C,D, then hold if_write with pop idle → count stays 4, D is not overwritten. Next, push+pop together → one pop only, count=3, if_dout=B.
- Simultaneous push+pop at count=2, DEPTH=4, holding X (oldest), Y: push Z with pop → count=2, addr unchanged, if_dout=Y next cycle, then Z after another pop.
- Empty-side collision: count=0, assert push W and pop together → pop ignored, count=1, if_dout=W next cycle.
- CE gating and async reset: if_write=1 with if_write_ce=0 → no push. Assert reset between clock edges with count=3 → flags go to 0/1 before the next edge and count=0.
